clint_timer: RTL and testbench

//  Core-local interruptor (CLINT) that produces the machine software (IRQ3 -> mip.MSIP) and

---
 rtl/clint_timer.sv | 197 +++++++++++++++++++
 tb/tb_clint_timer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/clint_timer.sv
// -----------------------------------------------------------------------------
// clint_timer -- core-local interruptor (CLINT)
//
// Generates the machine software interrupt (IRQ3, from msip[0]) and the machine
// timer interrupt (IRQ7, mtime >= mtimecmp) for the CSR/exception unit. It is a
// 64 KiB memory-bus slave holding a free-running 64-bit mtime, a 64-bit mtimecmp
// and a 1-bit msip register.
//
// Optional feature macro: CLINT_PRESCALER_EN
//   defined   : mtime ticks once every MTIME_DIV clocks (MTIME_DIV=0 acts as 1)
//   undefined : mtime ticks every clock, MTIME_DIV is ignored
//
// Ports
//   clk      in   1   system clock
//   resetn   in   1   synchronous, active-low reset
//   valid    in   1   bus request, held until ready
//   addr     in   16  byte offset inside the CLINT window ([1:0] ignored)
//   wmask    in   4   byte write strobes, 4'b0000 = read
//   wdata    in   32  write data
//   rdata    out  32  read data, valid while ready=1
//   ready    out  1   one-cycle completion pulse
//   IRQ3     out  1   machine software interrupt
//   IRQ7     out  1   machine timer interrupt
//   mtime_o  out  64  current mtime
// -----------------------------------------------------------------------------
module clint_timer #(
    parameter logic [15:0] MTIME_DIV = 16'd1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        valid,
    input  logic [15:0] addr,
    input  logic [3:0]  wmask,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        IRQ3,
    output logic        IRQ7,
    output logic [63:0] mtime_o
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned TIME_W = 64;
    localparam int unsigned WORD_W = 14;

    // Word offsets (byte offset >> 2) of the register map
    localparam logic [WORD_W-1:0] A_MSIP     = 14'h0000;
    localparam logic [WORD_W-1:0] A_CMP_LO   = 14'h1000;
    localparam logic [WORD_W-1:0] A_CMP_HI   = 14'h1001;
    localparam logic [WORD_W-1:0] A_MTIME_LO = 14'h2FFE;
    localparam logic [WORD_W-1:0] A_MTIME_HI = 14'h2FFF;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RESP = 1'b1
    } state_e;

    state_e              state_q;
    logic                msip_q;
    logic                msip_d;
    logic [TIME_W-1:0]   mtimecmp_q;
    logic [TIME_W-1:0]   mtimecmp_d;
    logic [TIME_W-1:0]   mtime_q;
    logic [TIME_W-1:0]   mtime_d;
    logic [DATA_W-1:0]   rdata_q;
    logic                ready_q;
    logic                irq3_q;
    logic                irq7_q;

    logic                txn_c;
    logic                tick_c;
    logic [WORD_W-1:0]   word_c;
    logic [DATA_W-1:0]   rd_c;
    logic                unused_addr_c;

    assign unused_addr_c = ^addr[1:0];
    assign word_c        = addr[15:2];

    // A request is accepted only when the bus FSM is idle
    assign txn_c = (state_q == S_IDLE) && valid;

    // Byte-strobe merge of new data over an old 32-bit word
    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] old_v,
        input logic [DATA_W-1:0] new_v,
        input logic [3:0]        mask
    );
        logic [DATA_W-1:0] res;
        res = old_v;
        for (int b = 0; b < 4; b++) begin
            if (mask[b]) begin
                res[b*8 +: 8] = new_v[b*8 +: 8];
            end
        end
        return res;
    endfunction

`ifdef CLINT_PRESCALER_EN
    // Prescaler: counts 0..DIV_EFF-1, mtime ticks on the wrap back to 0
    localparam logic [15:0] DIV_EFF = (MTIME_DIV == 16'd0) ? 16'd1 : MTIME_DIV;

    logic [15:0] presc_q;
    logic [15:0] presc_d;

    assign tick_c  = (presc_q == (DIV_EFF - 16'd1));
    assign presc_d = tick_c ? 16'd0 : (presc_q + 16'd1);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            presc_q <= 16'd0;
        end else begin
            presc_q <= presc_d;
        end
    end
`else
    logic unused_div_c;

    assign unused_div_c = ^MTIME_DIV;
    assign tick_c       = 1'b1;
`endif

    // Read mux and next-state of the registers; bus writes override the tick per byte
    always_comb begin
        msip_d     = msip_q;
        mtimecmp_d = mtimecmp_q;
        mtime_d    = tick_c ? (mtime_q + 64'd1) : mtime_q;
        rd_c       = '0;

        case (word_c)
            A_MSIP:     rd_c = {31'd0, msip_q};
            A_CMP_LO:   rd_c = mtimecmp_q[31:0];
            A_CMP_HI:   rd_c = mtimecmp_q[63:32];
            A_MTIME_LO: rd_c = mtime_q[31:0];
            A_MTIME_HI: rd_c = mtime_q[63:32];
            default:    rd_c = '0;
        endcase

        if (txn_c) begin
            case (word_c)
                A_MSIP: begin
                    if (wmask[0]) begin
                        msip_d = wdata[0];
                    end
                end
                A_CMP_LO:   mtimecmp_d[31:0]  = merge_bytes(mtimecmp_q[31:0], wdata, wmask);
                A_CMP_HI:   mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], wdata, wmask);
                A_MTIME_LO: mtime_d[31:0]     = merge_bytes(mtime_d[31:0], wdata, wmask);
                A_MTIME_HI: mtime_d[63:32]    = merge_bytes(mtime_d[63:32], wdata, wmask);
                default: ;
            endcase
        end
    end

    // Registers, interrupt outputs and the two-state bus FSM
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            msip_q     <= 1'b0;
            mtimecmp_q <= '1;
            mtime_q    <= '0;
            rdata_q    <= '0;
            ready_q    <= 1'b0;
            irq3_q     <= 1'b0;
            irq7_q     <= 1'b0;
        end else begin
            msip_q     <= msip_d;
            mtimecmp_q <= mtimecmp_d;
            mtime_q    <= mtime_d;
            irq3_q     <= msip_d;
            irq7_q     <= (mtime_d >= mtimecmp_d);
            ready_q    <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (valid) begin
                        rdata_q <= rd_c;
                        ready_q <= 1'b1;
                        state_q <= S_RESP;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign rdata   = rdata_q;
    assign ready   = ready_q;
    assign IRQ3    = irq3_q;
    assign IRQ7    = irq7_q;
    assign mtime_o = mtime_q;

endmodule

// File: tb/tb_clint_timer.sv
// -----------------------------------------------------------------------------
// tb_clint_timer -- self-checking bench for clint_timer
//
// A behavioural model (plain arithmetic on 64-bit values, updated per clock
// edge from the request the bench issued) predicts mtime, mtimecmp, msip, the
// interrupt levels and read data. Directed cases cover reset values, msip,
// timer compare, carry, byte masks and reset during a transaction; a random
// phase then mixes reads and writes over the whole register map.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_clint_timer;

`ifdef CLINT_PRESCALER_EN
    localparam logic [15:0] DIV = 16'd4;
`else
    localparam logic [15:0] DIV = 16'd1;
`endif

    logic        clk = 1'b0;
    logic        resetn;
    logic        valid;
    logic [15:0] addr;
    logic [3:0]  wmask;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        IRQ3;
    logic        IRQ7;
    logic [63:0] mtime_o;

    clint_timer #(.MTIME_DIV(DIV)) dut (
        .clk     (clk),
        .resetn  (resetn),
        .valid   (valid),
        .addr    (addr),
        .wmask   (wmask),
        .wdata   (wdata),
        .rdata   (rdata),
        .ready   (ready),
        .IRQ3    (IRQ3),
        .IRQ7    (IRQ7),
        .mtime_o (mtime_o)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [63:0] m_mtime;
    logic [63:0] m_cmp;
    logic        m_msip;
    logic [31:0] m_rdata;
    longint      m_cyc;
    int          req_seq  = 0;
    int          done_seq = 0;
    logic [15:0] p_addr;
    logic [3:0]  p_mask;
    logic [31:0] p_data;
    bit          chk_en = 1'b0;

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (m[b]) r[b*8 +: 8] = n[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_read(input logic [15:0] a);
        logic [15:0] w;
        w = {a[15:2], 2'b00};
        case (w)
            16'h0000: return {31'd0, m_msip};
            16'h4000: return m_cmp[31:0];
            16'h4004: return m_cmp[63:32];
            16'hBFF8: return m_mtime[31:0];
            16'hBFFC: return m_mtime[63:32];
            default:  return 32'd0;
        endcase
    endfunction

    always @(posedge clk) begin
        logic [63:0] nt;
        logic [15:0] w;
        if (!resetn) begin
            m_mtime  = 64'd0;
            m_cmp    = '1;
            m_msip   = 1'b0;
            m_cyc    = 0;
            done_seq = req_seq;
        end else begin
            m_cyc++;
            nt = ((m_cyc % longint'(DIV)) == 0) ? m_mtime + 64'd1 : m_mtime;
            if (req_seq != done_seq) begin
                done_seq = req_seq;
                m_rdata  = model_read(p_addr);
                w = {p_addr[15:2], 2'b00};
                case (w)
                    16'h0000: if (p_mask[0]) m_msip = p_data[0];
                    16'h4000: m_cmp[31:0]  = merge(m_cmp[31:0], p_data, p_mask);
                    16'h4004: m_cmp[63:32] = merge(m_cmp[63:32], p_data, p_mask);
                    16'hBFF8: nt[31:0]     = merge(nt[31:0], p_data, p_mask);
                    16'hBFFC: nt[63:32]    = merge(nt[63:32], p_data, p_mask);
                    default: ;
                endcase
            end
            m_mtime = nt;
        end
    end

    // Continuous comparison of the timer state and interrupt levels
    always @(negedge clk) begin
        if (chk_en) begin
            check("mtime_o", mtime_o, m_mtime);
            check("IRQ3", 64'(IRQ3), 64'(m_msip));
            check("IRQ7", 64'(IRQ7), 64'(m_mtime >= m_cmp));
        end
    end

    // One bus transfer; called just after a falling edge, returns after one
    // further falling edge so calls can run back to back
    task automatic bus(input logic [15:0] a, input logic [3:0] m, input logic [31:0] d,
                       output logic [31:0] rd);
        p_addr = a;
        p_mask = m;
        p_data = d;
        addr   = a;
        wmask  = m;
        wdata  = d;
        valid  = 1'b1;
        req_seq++;
        @(posedge clk);
        @(negedge clk);
        check("ready", 64'(ready), 64'd1);
        check($sformatf("rdata@%h", a), 64'(rdata), 64'(m_rdata));
        rd    = rdata;
        valid = 1'b0;
        wmask = 4'd0;
        @(negedge clk);
        check("ready_drop", 64'(ready), 64'd0);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1);
    end

    logic [31:0] rd;
    logic [15:0] ra;
    logic [31:0] rdv;
    bit          seen;

    initial begin
        resetn = 1'b0;
        valid  = 1'b0;
        addr   = 16'd0;
        wmask  = 4'd0;
        wdata  = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_mtime", mtime_o, 64'd0);
        check("rst_irq3", 64'(IRQ3), 64'd0);
        check("rst_irq7", 64'(IRQ7), 64'd0);
        check("rst_ready", 64'(ready), 64'd0);
        check("rst_rdata", 64'(rdata), 64'd0);
        chk_en = 1'b1;
        resetn = 1'b1;

        repeat (10 * int'(DIV)) @(negedge clk);
        check("idle10_mtime", mtime_o, 64'd10);
        bus(16'h4004, 4'h0, 32'd0, rd);
        check("cmp_hi_reset", 64'(rd), 64'hFFFF_FFFF);
        bus(16'h8000, 4'h0, 32'd0, rd);
        check("unmapped_read", 64'(rd), 64'd0);

        bus(16'h0000, 4'hF, 32'd1, rd);
        check("msip_set_irq3", 64'(IRQ3), 64'd1);
        bus(16'h0000, 4'hF, 32'd0, rd);
        check("msip_clr_irq3", 64'(IRQ3), 64'd0);

        // Timer compare at 0x20
        bus(16'h4000, 4'hF, 32'h20, rd);
        bus(16'h4004, 4'hF, 32'h0, rd);
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            if (mtime_o == 64'h20) seen = 1'b1;
            else @(negedge clk);
        end
        check("reach_0x20", 64'(seen), 64'd1);
        check("irq7_at_cmp", 64'(IRQ7), 64'd1);
        bus(16'h4000, 4'hF, 32'h1000, rd);
        check("irq7_cmp_raised", 64'(IRQ7), 64'd0);

        // Carry from lower to upper half
        bus(16'hBFFC, 4'hF, 32'h0, rd);
        bus(16'hBFF8, 4'hF, 32'hFFFF_FFFE, rd);
`ifndef CLINT_PRESCALER_EN
        @(negedge clk);
        check("mtime_carry", mtime_o, 64'h1_0000_0000);
`endif
        repeat (3 * int'(DIV)) @(negedge clk);

        // Byte-masked write to mtimecmp after reset
        do_reset();
        bus(16'h4000, 4'b0010, 32'h0000_AB00, rd);
        bus(16'h4000, 4'h0, 32'd0, rd);
        check("cmp_lo_bytemask", 64'(rd), 64'hFFFF_ABFF);

        // Reset arriving with a pending write discards it
        bus(16'h0000, 4'hF, 32'd1, rd);
        p_addr = 16'h0000;
        p_mask = 4'hF;
        p_data = 32'd1;
        addr   = 16'h0000;
        wmask  = 4'hF;
        wdata  = 32'd1;
        valid  = 1'b1;
        resetn = 1'b0;
        req_seq++;
        @(negedge clk);
        check("midrst_ready", 64'(ready), 64'd0);
        check("midrst_irq3", 64'(IRQ3), 64'd0);
        valid  = 1'b0;
        wmask  = 4'd0;
        resetn = 1'b1;
        @(negedge clk);

        // Random mix of reads and writes across the map
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 6))
                0: ra = 16'h0000;
                1: ra = 16'h4000;
                2: ra = 16'h4004;
                3: ra = 16'hBFF8;
                4: ra = 16'hBFFC;
                5: ra = 16'($urandom);
                default: ra = 16'h4000 | 16'($urandom_range(0, 7));
            endcase
            ra[1:0] = 2'($urandom_range(0, 3));
            rdv = ($urandom_range(0, 2) == 0) ? $urandom : 32'($urandom_range(0, 96));
            bus(ra, 4'($urandom_range(0, 15)), rdv, rd);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
